rbs_seq_sub: RTL and testbench

//   Multi-cycle ripple-borrow subtractor: inverse of the generate-built ripple-carry adder.

---
 rtl/rbs_pkg.sv | 20 ++
 rtl/rbs_slice.sv | 23 ++
 rtl/rbs_seq_sub.sv | 125 ++++++++++++
 tb/tb_rbs_seq_sub.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbs_pkg.sv
// Shared definitions for the ripple-borrow subtractor and its ripple-carry adder sibling.
// Holds the FSM state encoding and a constant-evaluable ceiling-log2 helper.
package rbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rbs_state_e;

  function automatic int rbs_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rbs_slice.sv
// C-bit combinational ripple-borrow chain built from 1-bit full subtractors.
module rbs_slice #(
  parameter int C = 8
) (
  input  logic [C-1:0] i_x,
  input  logic [C-1:0] i_y,
  input  logic         i_bin,
  output logic [C-1:0] o_d,
  output logic         o_bout
);

  logic [C:0] w_borrow;

  assign w_borrow[0] = i_bin;

  for (genvar i = 0; i < C; i++) begin : g_bit
    assign o_d[i]          = i_x[i] ^ i_y[i] ^ w_borrow[i];
    assign w_borrow[i + 1] = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & w_borrow[i]);
  end

  assign o_bout = w_borrow[C];

endmodule

// File: rtl/rbs_seq_sub.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, one C-bit slice per clock.
// Optional feature macro: RBS_ZERO_FLAG_EN adds the 'zero' output and its accumulator.
module rbs_seq_sub
  import rbs_pkg::*;
#(
  parameter int G = 128,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [G-1:0] diff,
  output logic         bout
`ifdef RBS_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int N  = G / C;
  localparam int CW = (rbs_clog2(N) < 1) ? 1 : rbs_clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  rbs_state_e      r_state;
  rbs_state_e      w_nextState;
  logic [CW-1:0]   r_k;
  logic [G-1:0]    r_a;
  logic [G-1:0]    r_b;
  logic            r_brw;
  logic [G-1:0]    r_diff;
  logic            r_bout;
  logic            w_accept;
  logic            w_busy;
  logic            w_lastSlice;
  logic [C-1:0]    w_d;
  logic            w_brwNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = BUSY;
      end
      BUSY: begin
        if (w_lastSlice) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_accept    = in_ready & in_valid;
  assign w_busy      = (r_state == BUSY);
  assign w_lastSlice = w_busy && (r_k == LAST);

  rbs_slice #(.C(C)) u_slice (
    .i_x    (r_a[r_k*C +: C]),
    .i_y    (r_b[r_k*C +: C]),
    .i_bin  (r_brw),
    .o_d    (w_d),
    .o_bout (w_brwNext)
  );

  // Operands are frozen at accept; the slice walks them LSB-first, carrying the borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_brw  <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_brw <= bin;
      r_k   <= '0;
    end else if (w_busy) begin
      r_diff[r_k*C +: C] <= w_d;
      r_brw              <= w_brwNext;
      r_k                <= r_k + 1'b1;
      if (w_lastSlice) r_bout <= w_brwNext;
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

`ifdef RBS_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_zero <= 1'b1;
    end else if (w_busy) begin
      r_zero <= r_zero & (w_d == '0);
    end
  end

  assign zero = r_zero;
`endif

endmodule

// File: tb/tb_rbs_seq_sub.sv
// Self-checking bench for rbs_seq_sub: directed scenarios plus randomized operands
// compared against a plain (G+1)-bit arithmetic reference model.
module tb_rbs_seq_sub;

  localparam int G = 128;
  localparam int C = 8;
  localparam int N = G / C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [G-1:0] a, b, diff;
  logic         in_valid8, in_ready8, out_valid8, out_ready8, bin8, bout8;
  logic [7:0]   a8, b8, diff8;
`ifdef RBS_ZERO_FLAG_EN
  logic         zero, zero8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rbs_seq_sub #(.G(G), .C(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef RBS_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  rbs_seq_sub #(.G(8), .C(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .bin       (bin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .diff      (diff8),
    .bout      (bout8)
`ifdef RBS_ZERO_FLAG_EN
    ,
    .zero      (zero8)
`endif
  );

  // Reference: the top bit of the (G+1)-bit difference is the unsigned borrow-out.
  function automatic logic [G:0] model(input logic [G-1:0] x, input logic [G-1:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {{G{1'b0}}, bi};
  endfunction

  function automatic logic [G-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Waits (bounded) for in_ready, then presents one operand set for a single cycle.
  task automatic send(input logic [G-1:0] x, input logic [G-1:0] y, input logic bi);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    a        = x;
    b        = y;
    bin      = bi;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    bin        = 1'b0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    a8         = '0;
    b8         = '0;
    bin8       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (diff !== '0) begin failures++; $display("[TB] FAIL reset_diff: got %h want 0", diff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("[TB] FAIL reset_bout: got %b want 0", bout); end
`ifdef RBS_ZERO_FLAG_EN
    checks++; if (zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_zero: got %b want 0", zero); end
`endif
  endtask

  task automatic test_basic();
    int cnt;
    logic [G-1:0] held;
    send(128'd100, 128'd37, 1'b0);
    wait_done(cnt);
    checks++; if (cnt != N) begin failures++; $display("[TB] FAIL basic_latency: got %0d want %0d", cnt, N); end
    checks++; if (diff !== 128'd63) begin failures++; $display("[TB] FAIL basic_diff: got %0d want 63", diff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("[TB] FAIL basic_bout: got %b want 0", bout); end
    held = diff;
    for (int i = 0; i < 5; i++) begin
      a = rand_word();
      @(negedge clk);
      checks++; if (diff !== 128'd63 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL basic_hold: cycle %0d diff=%0d out_valid=%b in_ready=%b want 63/1/0", i, diff, out_valid, in_ready);
      end
    end
    take();
    checks++; if (out_valid !== 1'b0 || diff !== held) begin failures++; $display("[TB] FAIL basic_taken: out_valid=%b diff=%0d want 0/63", out_valid, diff); end
  endtask

  task automatic test_full_borrow();
    int cnt;
    send('0, '0, 1'b1);
    wait_done(cnt);
    checks++; if (diff !== {G{1'b1}}) begin failures++; $display("[TB] FAIL fullborrow_diff: got %h want all ones", diff); end
    checks++; if (bout !== 1'b1) begin failures++; $display("[TB] FAIL fullborrow_bout: got %b want 1", bout); end
`ifdef RBS_ZERO_FLAG_EN
    checks++; if (zero !== 1'b0) begin failures++; $display("[TB] FAIL fullborrow_zero: got %b want 0", zero); end
`endif
    take();
    send(128'd55, 128'd55, 1'b0);
    wait_done(cnt);
    checks++; if (diff !== '0) begin failures++; $display("[TB] FAIL equal_diff: got %h want 0", diff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("[TB] FAIL equal_bout: got %b want 0", bout); end
`ifdef RBS_ZERO_FLAG_EN
    checks++; if (zero !== 1'b1) begin failures++; $display("[TB] FAIL equal_zero: got %b want 1", zero); end
`endif
    take();
  endtask

  task automatic test_cross_slice();
    int cnt;
    logic [G-1:0] x;
    logic [G-1:0] expDiff;
    x       = '0;
    x[64]   = 1'b1;
    expDiff = x - 128'd1;
    send(x, 128'd1, 1'b0);
    wait_done(cnt);
    checks++; if (diff !== expDiff) begin failures++; $display("[TB] FAIL cross_diff: got %h want %h", diff, expDiff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("[TB] FAIL cross_bout: got %b want 0", bout); end
    take();
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("[TB] FAIL n1_in_ready: got %b want 1", in_ready8); end
    a8        = 8'd5;
    b8        = 8'd9;
    bin8      = 1'b0;
    in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    cnt = 0;
    while (!out_valid8 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt != 1) begin failures++; $display("[TB] FAIL n1_latency: got %0d want 1", cnt); end
    checks++; if (diff8 !== 8'd252) begin failures++; $display("[TB] FAIL n1_diff: got %0d want 252", diff8); end
    checks++; if (bout8 !== 1'b1) begin failures++; $display("[TB] FAIL n1_bout: got %b want 1", bout8); end
`ifdef RBS_ZERO_FLAG_EN
    checks++; if (zero8 !== 1'b0) begin failures++; $display("[TB] FAIL n1_zero: got %b want 0", zero8); end
`endif
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("[TB] FAIL n1_taken: got %b want 0", out_valid8); end
  endtask

  task automatic test_handshake();
    int cnt;
    logic [G-1:0] x1, y1, x2, y2;
    logic [G:0]   exp1, exp2;
    x1 = rand_word(); y1 = rand_word();
    x2 = rand_word(); y2 = rand_word();
    exp1 = model(x1, y1, 1'b0);
    exp2 = model(x2, y2, 1'b1);
    send(x1, y1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = rand_word(); b = rand_word(); bin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL busy_in_ready: cycle %0d got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    wait_done(cnt);
    checks++; if (cnt + 5 != N) begin failures++; $display("[TB] FAIL busy_latency: got %0d want %0d", cnt + 5, N); end
    checks++; if ({bout, diff} !== exp1) begin failures++; $display("[TB] FAIL busy_ignore: got %b_%h want %b_%h", bout, diff, exp1[G], exp1[G-1:0]); end
    a = x2; b = y2; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL done_take: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL idle_accept: in_ready=%b want 0", in_ready); end
    wait_done(cnt);
    checks++; if (cnt != N) begin failures++; $display("[TB] FAIL second_latency: got %0d want %0d", cnt, N); end
    checks++; if ({bout, diff} !== exp2) begin failures++; $display("[TB] FAIL second_result: got %b_%h want %b_%h", bout, diff, exp2[G], exp2[G-1:0]); end
    take();
  endtask

  task automatic test_reset_mid_op();
    int cnt;
    send(rand_word(), rand_word(), 1'b1);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (diff !== '0 || bout !== 1'b0) begin failures++; $display("[TB] FAIL abort_outputs: diff=%h bout=%b want 0/0", diff, bout); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(128'd10, 128'd3, 1'b0);
    wait_done(cnt);
    checks++; if (cnt != N) begin failures++; $display("[TB] FAIL after_abort_latency: got %0d want %0d", cnt, N); end
    checks++; if (diff !== 128'd7 || bout !== 1'b0) begin failures++; $display("[TB] FAIL after_abort_result: diff=%0d bout=%b want 7/0", diff, bout); end
    take();
  endtask

  task automatic test_random();
    int cnt;
    int stall;
    logic [G-1:0] x, y;
    logic         bi;
    logic [G:0]   exp;
    logic         unstable;
    for (int it = 0; it < 1000; it++) begin
      x  = rand_word();
      bi = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       y = x;
        1:       y = x + G'($urandom_range(0, 3));
        2:       y = x - G'($urandom_range(0, 3));
        default: y = rand_word();
      endcase
      exp = model(x, y, bi);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(x, y, bi);
      wait_done(cnt);
      checks++; if (cnt != N) begin failures++; $display("[TB] FAIL rand_latency: iter %0d got %0d want %0d", it, cnt, N); end
      checks++; if (diff !== exp[G-1:0]) begin failures++; $display("[TB] FAIL rand_diff: iter %0d got %h want %h", it, diff, exp[G-1:0]); end
      checks++; if (bout !== exp[G]) begin failures++; $display("[TB] FAIL rand_bout: iter %0d got %b want %b", it, bout, exp[G]); end
`ifdef RBS_ZERO_FLAG_EN
      checks++; if (zero !== (exp[G-1:0] == '0)) begin failures++; $display("[TB] FAIL rand_zero: iter %0d got %b want %b", it, zero, (exp[G-1:0] == '0)); end
`endif
      stall    = $urandom_range(0, 3);
      unstable = 1'b0;
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'($urandom_range(0, 1));
        a = rand_word();
        @(negedge clk);
        if (diff !== exp[G-1:0] || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
      end
      in_valid = 1'b0;
      checks++; if (unstable !== 1'b0) begin failures++; $display("[TB] FAIL rand_stall_hold: iter %0d diff=%h out_valid=%b want %h/1", it, diff, out_valid, exp[G-1:0]); end
      take();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full_borrow();
    test_cross_slice();
    test_handshake();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
